// File: rtl/layer4_pkg.sv
// Shared constants and types for the Layer 4 output path.
// The DMA glue downstream of the packer reuses the widths and the word
// layout defined here, so they live in one place.
package layer4_pkg;

  // Stream geometry: 8-bit activations packed four to a 32-bit DMA word.
  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam int LANES  = WORD_W / BYTE_W;
  localparam int KEEP_W = LANES;
  localparam int LANE_W = $clog2(LANES);

  // One 56x56 feature map of Layer 4 output activations.
  localparam int L4_FRAME_BYTES = 3136;

  // Depth of the word buffer between the packer and the DMA.
  localparam int FIFO_DEPTH = 2;

  // One DMA beat as it sits in the output buffer.
  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
  } outWord_t;

  localparam int PAYLOAD_W = WORD_W + KEEP_W + 1;

  // Byte enables for a word whose highest written lane is 'lane'.
  // Lanes always fill from 0 upward, so the mask is contiguous from bit 0.
  function automatic logic [KEEP_W-1:0] keepUpTo(input logic [LANE_W-1:0] lane);
    logic [KEEP_W-1:0] mask;
    case (lane)
      2'd0:    mask = 4'b0001;
      2'd1:    mask = 4'b0011;
      2'd2:    mask = 4'b0111;
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry register FIFO.
// slot0 is always the head and drives the consumer directly from a flop,
// so the head data and the valid flag are both registered. Pushing into a
// full FIFO without a simultaneous pop is ignored; the producer is expected
// to look at 'count' and never try.
module stream_fifo2 #(
  parameter int WIDTH = 37
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             pushEn,
  input  logic [WIDTH-1:0] pushData,
  input  logic             popEn,
  output logic [WIDTH-1:0] headData,
  output logic             headValid,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] slot0;
  logic [WIDTH-1:0] slot1;
  logic [1:0]       countQ;
  logic             validQ;
  logic             pushOk;
  logic             popOk;
  logic [1:0]       countNext;

  // Qualify the requests against the current fill level and work out the new level.
  always_comb begin
    popOk     = popEn && (countQ != 2'd0);
    pushOk    = pushEn && ((countQ != 2'd2) || popOk);
    countNext = countQ + {1'b0, pushOk} - {1'b0, popOk};
  end

  // Move entries toward the head on a pop and land a push in the first free slot.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      slot0  <= '0;
      slot1  <= '0;
      countQ <= 2'd0;
      validQ <= 1'b0;
    end else begin
      case ({pushOk, popOk})
        2'b10: begin
          if (countQ == 2'd0) begin
            slot0 <= pushData;
          end else begin
            slot1 <= pushData;
          end
        end
        2'b01: begin
          slot0 <= slot1;
        end
        2'b11: begin
          if (countQ == 2'd1) begin
            slot0 <= pushData;
          end else begin
            slot0 <= slot1;
            slot1 <= pushData;
          end
        end
        default: begin
        end
      endcase
      countQ <= countNext;
      validQ <= (countNext != 2'd0);
    end
  end

  assign headData  = slot0;
  assign headValid = validQ;
  assign count     = countQ;

endmodule

// File: rtl/layer4_out_packer.sv
// Layer 4 output packer.
// Collects the post-ReLU byte stream little-endian into 32-bit words and
// hands them to the output DMA through a two-word buffer. Each feature-map
// frame ends on its own word: a short tail word carries a partial TKEEP and
// TLAST, and the next frame always restarts in lane 0.
module layer4_out_packer
  import layer4_pkg::*;
#(
  parameter int FRAME_BYTES = L4_FRAME_BYTES
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [BYTE_W-1:0] reluRes_V_V_TDATA,
  input  logic              reluRes_V_V_TVALID,
  output logic              reluRes_V_V_TREADY,
  output logic [WORD_W-1:0] OutDMA_V_TDATA,
  output logic [KEEP_W-1:0] OutDMA_V_TKEEP,
  output logic              OutDMA_V_TLAST,
  output logic              OutDMA_V_TVALID,
  input  logic              OutDMA_V_TREADY,
  output logic [15:0]       frame_cnt
);

  localparam logic [15:0]       LAST_IDX  = 16'(FRAME_BYTES - 1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  logic [LANE_W-1:0]    laneIdx;
  logic [15:0]          byteCnt;
  logic [WORD_W-1:0]    packData;
  logic [WORD_W-1:0]    wordNext;
  logic [15:0]          frameCntQ;

  logic                 inReady;
  logic                 byteAccept;
  logic                 lastByte;
  logic                 wordDone;
  outWord_t             pushWord;

  logic [PAYLOAD_W-1:0] fifoHead;
  logic                 fifoValid;
  logic [1:0]           fifoCount;
  logic                 wordPop;
  outWord_t             headWord;

  // Input handshake: ready whenever there is room for a word, so a byte
  // that completes a word always has a slot to land in.
  always_comb begin
    inReady    = ap_rst_n && (fifoCount < 2'(FIFO_DEPTH));
    byteAccept = reluRes_V_V_TVALID && inReady;
    lastByte   = (byteCnt == LAST_IDX);
    wordDone   = byteAccept && ((laneIdx == LAST_LANE) || lastByte);
  end

  // Merge the incoming byte into the pack register to form the candidate word.
  always_comb begin
    wordNext = packData;
    wordNext[{laneIdx, 3'b000} +: BYTE_W] = reluRes_V_V_TDATA;
    pushWord.data = wordNext;
    pushWord.keep = keepUpTo(laneIdx);
    pushWord.last = lastByte;
  end

  // Lane and frame position tracking; a finished word clears the pack
  // register so unwritten lanes of the next short word read as zero.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      laneIdx  <= '0;
      byteCnt  <= 16'd0;
      packData <= '0;
    end else if (byteAccept) begin
      if (wordDone) begin
        laneIdx  <= '0;
        packData <= '0;
      end else begin
        laneIdx  <= laneIdx + LANE_W'(1);
        packData <= wordNext;
      end
      if (lastByte) begin
        byteCnt <= 16'd0;
      end else begin
        byteCnt <= byteCnt + 16'd1;
      end
    end
  end

  stream_fifo2 #(
    .WIDTH (PAYLOAD_W)
  ) wordFifo (
    .clock     (ap_clk),
    .resetN    (ap_rst_n),
    .pushEn    (wordDone),
    .pushData  (pushWord),
    .popEn     (wordPop),
    .headData  (fifoHead),
    .headValid (fifoValid),
    .count     (fifoCount)
  );

  // Decode the buffer head and detect the DMA taking it.
  always_comb begin
    headWord = outWord_t'(fifoHead);
    wordPop  = fifoValid && OutDMA_V_TREADY;
  end

  // Count frames as their last word leaves toward the DMA.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      frameCntQ <= 16'd0;
    end else if (wordPop && headWord.last) begin
      frameCntQ <= frameCntQ + 16'd1;
    end
  end

  assign reluRes_V_V_TREADY = inReady;
  assign OutDMA_V_TDATA     = headWord.data;
  assign OutDMA_V_TKEEP     = headWord.keep;
  assign OutDMA_V_TLAST     = headWord.last;
  assign OutDMA_V_TVALID    = fifoValid;
  assign frame_cnt          = frameCntQ;

endmodule

// File: tb/tb_layer4_out_packer.sv
// Testbench for layer4_out_packer.
// Four instances with different frame lengths share clock and reset; each
// scenario drives one of them. Expected words go into a queue as stimulus
// is planned or accepted and are popped as the DMA side takes words.
module tb_layer4_out_packer;

  localparam int NDUT = 4;
  localparam int FB_BIG = 3136;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } expWord_t;

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;

  logic [7:0]  inData   [NDUT];
  logic        inValid  [NDUT];
  logic        inReady  [NDUT];
  logic [31:0] outData  [NDUT];
  logic [3:0]  outKeep  [NDUT];
  logic        outLast  [NDUT];
  logic        outValid [NDUT];
  logic        outReady [NDUT];
  logic [15:0] frameCnt [NDUT];

  expWord_t expQ[$];
  int checks = 0;
  int errors = 0;

  int          mLane;
  int          mCnt;
  logic [31:0] mWord;

  always #5 ap_clk = ~ap_clk;

  // Instance 0: 8-byte frames, 1: 6-byte, 2: full 56x56 map, 3: 1-byte.
  for (genvar g = 0; g < NDUT; g++) begin : gDut
    localparam int FB = (g == 0) ? 8 : (g == 1) ? 6 : (g == 2) ? FB_BIG : 1;
    layer4_out_packer #(
      .FRAME_BYTES (FB)
    ) dut (
      .ap_clk             (ap_clk),
      .ap_rst_n           (ap_rst_n),
      .reluRes_V_V_TDATA  (inData[g]),
      .reluRes_V_V_TVALID (inValid[g]),
      .reluRes_V_V_TREADY (inReady[g]),
      .OutDMA_V_TDATA     (outData[g]),
      .OutDMA_V_TKEEP     (outKeep[g]),
      .OutDMA_V_TLAST     (outLast[g]),
      .OutDMA_V_TVALID    (outValid[g]),
      .OutDMA_V_TREADY    (outReady[g]),
      .frame_cnt          (frameCnt[g])
    );
  end

  task automatic modelReset();
    mLane = 0;
    mCnt  = 0;
    mWord = 32'h0;
  endtask

  // Reference packer: fold one accepted byte in, queue a word when one closes.
  task automatic modelByte(input int fb, input logic [7:0] b);
    expWord_t w;
    mWord[mLane*8 +: 8] = b;
    mCnt++;
    if (mLane == 3 || mCnt == fb) begin
      w.data = mWord;
      w.keep = 4'((1 << (mLane + 1)) - 1);
      w.last = (mCnt == fb);
      expQ.push_back(w);
      mWord = 32'h0;
      mLane = 0;
      if (mCnt == fb) mCnt = 0;
    end else begin
      mLane++;
    end
  endtask

  // One clock cycle on instance k: drive at the falling edge, sample 1 unit later.
  task automatic stepCycle(input int k, input logic v, input logic [7:0] d, input logic r,
                           output logic acc, output logic pop, output expWord_t obs);
    @(negedge ap_clk);
    inValid[k]  = v;
    inData[k]   = d;
    outReady[k] = r;
    #1;
    acc = inValid[k] && inReady[k];
    pop = outValid[k] && outReady[k];
    obs.data = outData[k];
    obs.keep = outKeep[k];
    obs.last = outLast[k];
  endtask

  task automatic assertReset();
    @(negedge ap_clk);
    ap_rst_n = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      inValid[k]  = 1'b0;
      outReady[k] = 1'b1;
    end
    @(posedge ap_clk);
    #1;
  endtask

  task automatic releaseReset();
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    modelReset();
    expQ.delete();
    #1;
  endtask

  task automatic test_reset();
    assertReset();
    for (int k = 0; k < NDUT; k++) begin
      checks += 6;
      if (inReady[k] !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready[%0d]: got %b, expected 0", k, inReady[k]); end
      if (outValid[k] !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid[%0d]: got %b, expected 0", k, outValid[k]); end
      if (outData[k] !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_data[%0d]: got %h, expected 0", k, outData[k]); end
      if (outKeep[k] !== 4'h0) begin errors++; $display("[TB] FAIL reset_out_keep[%0d]: got %h, expected 0", k, outKeep[k]); end
      if (outLast[k] !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_last[%0d]: got %b, expected 0", k, outLast[k]); end
      if (frameCnt[k] !== 16'h0) begin errors++; $display("[TB] FAIL reset_frame_cnt[%0d]: got %h, expected 0", k, frameCnt[k]); end
    end
    releaseReset();
    for (int k = 0; k < NDUT; k++) begin
      checks++;
      if (inReady[k] !== 1'b1) begin errors++; $display("[TB] FAIL release_in_ready[%0d]: got %b, expected 1", k, inReady[k]); end
    end
  endtask

  task automatic test_full_frame();
    int sent = 0;
    int budget;
    logic acc, pop, wantValid;
    expWord_t obs, exp;
    wantValid = 1'b0;
    expQ.push_back('{32'h04030201, 4'hF, 1'b0});
    expQ.push_back('{32'h08070605, 4'hF, 1'b1});
    for (budget = 0; budget < 40 && (sent < 8 || expQ.size() != 0); budget++) begin
      stepCycle(0, sent < 8, 8'(sent + 1), 1'b1, acc, pop, obs);
      if (wantValid) begin
        checks++;
        if (outValid[0] !== 1'b1) begin errors++; $display("[TB] FAIL full_frame_latency: valid=%b, expected 1", outValid[0]); end
      end
      wantValid = 1'b0;
      if (pop) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++; $display("[TB] FAIL full_frame_extra: got %h, expected no word", obs.data);
        end else begin
          exp = expQ.pop_front();
          if (obs !== exp) begin errors++; $display("[TB] FAIL full_frame_word: got %h/%h/%b, expected %h/%h/%b", obs.data, obs.keep, obs.last, exp.data, exp.keep, exp.last); end
        end
      end
      if (acc) begin
        sent++;
        if (sent % 4 == 0) wantValid = 1'b1;
      end
    end
    checks++;
    if (sent != 8 || expQ.size() != 0) begin errors++; $display("[TB] FAIL full_frame_timeout: sent %0d, pending %0d, expected 8 and 0", sent, expQ.size()); end
    stepCycle(0, 1'b0, 8'h0, 1'b1, acc, pop, obs);
    checks++;
    if (frameCnt[0] !== 16'd1) begin errors++; $display("[TB] FAIL full_frame_cnt: got %0d, expected 1", frameCnt[0]); end
  endtask

  task automatic test_partial_tail();
    int sent = 0;
    int budget;
    logic acc, pop;
    logic [7:0] b;
    expWord_t obs, exp;
    expQ.push_back('{32'hA3A2A1A0, 4'hF, 1'b0});
    expQ.push_back('{32'h0000A5A4, 4'h3, 1'b1});
    expQ.push_back('{32'hB3B2B1B0, 4'hF, 1'b0});
    expQ.push_back('{32'h0000B5B4, 4'h3, 1'b1});
    for (budget = 0; budget < 60 && (sent < 12 || expQ.size() != 0); budget++) begin
      b = (sent < 6) ? 8'(8'hA0 + sent) : 8'(8'hB0 + sent - 6);
      stepCycle(1, sent < 12, b, 1'b1, acc, pop, obs);
      if (pop) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++; $display("[TB] FAIL partial_extra: got %h, expected no word", obs.data);
        end else begin
          exp = expQ.pop_front();
          if (obs !== exp) begin errors++; $display("[TB] FAIL partial_word: got %h/%h/%b, expected %h/%h/%b", obs.data, obs.keep, obs.last, exp.data, exp.keep, exp.last); end
        end
      end
      if (acc) sent++;
    end
    checks++;
    if (sent != 12 || expQ.size() != 0) begin errors++; $display("[TB] FAIL partial_timeout: sent %0d, pending %0d, expected 12 and 0", sent, expQ.size()); end
    stepCycle(1, 1'b0, 8'h0, 1'b1, acc, pop, obs);
    checks++;
    if (frameCnt[1] !== 16'd2) begin errors++; $display("[TB] FAIL partial_frame_cnt: got %0d, expected 2", frameCnt[1]); end
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int budget;
    logic acc, pop;
    expWord_t obs, exp;
    modelReset();
    for (int c = 0; c < 20; c++) begin
      stepCycle(0, sent < 16, 8'(8'h30 + sent), 1'b0, acc, pop, obs);
      if (expQ.size() != 0) begin
        checks++;
        if (outValid[0] !== 1'b1 || obs !== expQ[0]) begin errors++; $display("[TB] FAIL stall_head: got %b %h/%h/%b, expected 1 %h/%h/%b", outValid[0], obs.data, obs.keep, obs.last, expQ[0].data, expQ[0].keep, expQ[0].last); end
      end
      if (acc) begin
        modelByte(8, 8'(8'h30 + sent));
        sent++;
      end
    end
    checks += 2;
    if (sent != 8) begin errors++; $display("[TB] FAIL stall_accepted: got %0d bytes, expected 8", sent); end
    if (inReady[0] !== 1'b0) begin errors++; $display("[TB] FAIL stall_in_ready: got %b, expected 0", inReady[0]); end
    for (budget = 0; budget < 60 && (sent < 16 || expQ.size() != 0); budget++) begin
      stepCycle(0, sent < 16, 8'(8'h30 + sent), 1'b1, acc, pop, obs);
      if (pop) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++; $display("[TB] FAIL drain_extra: got %h, expected no word", obs.data);
        end else begin
          exp = expQ.pop_front();
          if (obs !== exp) begin errors++; $display("[TB] FAIL drain_word: got %h/%h/%b, expected %h/%h/%b", obs.data, obs.keep, obs.last, exp.data, exp.keep, exp.last); end
        end
      end
      if (acc) begin
        modelByte(8, 8'(8'h30 + sent));
        sent++;
      end
    end
    checks++;
    if (sent != 16 || expQ.size() != 0) begin errors++; $display("[TB] FAIL drain_timeout: sent %0d, pending %0d, expected 16 and 0", sent, expQ.size()); end
    stepCycle(0, 1'b0, 8'h0, 1'b1, acc, pop, obs);
    checks++;
    if (frameCnt[0] !== 16'd3) begin errors++; $display("[TB] FAIL drain_frame_cnt: got %0d, expected 3", frameCnt[0]); end
  endtask

  task automatic test_random();
    int total = 10 * FB_BIG;
    int sent = 0;
    int rx = 0;
    int wordsInFrame = 0;
    int budget;
    logic acc, pop, v, r;
    logic [31:0] expData;
    expWord_t obs;
    for (budget = 0; budget < 60000 && rx < total; budget++) begin
      v = (sent < total) && ($urandom_range(0, 9) != 0);
      r = ($urandom_range(0, 3) != 0);
      stepCycle(2, v, 8'(sent), r, acc, pop, obs);
      if (pop) begin
        wordsInFrame++;
        expData = {8'(rx + 3), 8'(rx + 2), 8'(rx + 1), 8'(rx)};
        checks++;
        if (obs.data !== expData || obs.keep !== 4'hF || obs.last !== (wordsInFrame == 784)) begin
          errors++;
          $display("[TB] FAIL random_word %0d: got %h/%h/%b, expected %h/f/%b", rx / 4, obs.data, obs.keep, obs.last, expData, wordsInFrame == 784);
        end
        rx += 4;
        if (wordsInFrame == 784) wordsInFrame = 0;
      end
      if (acc) sent++;
    end
    checks++;
    if (rx != total) begin errors++; $display("[TB] FAIL random_timeout: received %0d bytes, expected %0d", rx, total); end
    stepCycle(2, 1'b0, 8'h0, 1'b1, acc, pop, obs);
    checks++;
    if (frameCnt[2] !== 16'd10) begin errors++; $display("[TB] FAIL random_frame_cnt: got %0d, expected 10", frameCnt[2]); end
  endtask

  task automatic test_reset_mid_word();
    int sent = 0;
    int budget;
    logic acc, pop;
    expWord_t obs, exp;
    for (int c = 0; c < 3; c++) begin
      stepCycle(0, 1'b1, 8'(8'hC0 + c), 1'b1, acc, pop, obs);
      checks++;
      if (pop || !acc) begin errors++; $display("[TB] FAIL midword_pre: acc=%b pop=%b, expected acc=1 pop=0", acc, pop); end
    end
    assertReset();
    checks += 6;
    if (inReady[0] !== 1'b0) begin errors++; $display("[TB] FAIL midword_in_ready: got %b, expected 0", inReady[0]); end
    if (outValid[0] !== 1'b0) begin errors++; $display("[TB] FAIL midword_out_valid: got %b, expected 0", outValid[0]); end
    if (outData[0] !== 32'h0) begin errors++; $display("[TB] FAIL midword_out_data: got %h, expected 0", outData[0]); end
    if (outKeep[0] !== 4'h0) begin errors++; $display("[TB] FAIL midword_out_keep: got %h, expected 0", outKeep[0]); end
    if (outLast[0] !== 1'b0) begin errors++; $display("[TB] FAIL midword_out_last: got %b, expected 0", outLast[0]); end
    if (frameCnt[0] !== 16'h0) begin errors++; $display("[TB] FAIL midword_frame_cnt: got %h, expected 0", frameCnt[0]); end
    releaseReset();
    expQ.push_back('{32'hD3D2D1D0, 4'hF, 1'b0});
    expQ.push_back('{32'hD7D6D5D4, 4'hF, 1'b1});
    for (budget = 0; budget < 40 && (sent < 8 || expQ.size() != 0); budget++) begin
      stepCycle(0, sent < 8, 8'(8'hD0 + sent), 1'b1, acc, pop, obs);
      if (pop) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++; $display("[TB] FAIL midword_extra: got %h, expected no word", obs.data);
        end else begin
          exp = expQ.pop_front();
          if (obs !== exp) begin errors++; $display("[TB] FAIL midword_word: got %h/%h/%b, expected %h/%h/%b", obs.data, obs.keep, obs.last, exp.data, exp.keep, exp.last); end
        end
      end
      if (acc) sent++;
    end
    checks++;
    if (sent != 8 || expQ.size() != 0) begin errors++; $display("[TB] FAIL midword_timeout: sent %0d, pending %0d, expected 8 and 0", sent, expQ.size()); end
    stepCycle(0, 1'b0, 8'h0, 1'b1, acc, pop, obs);
    checks++;
    if (frameCnt[0] !== 16'd1) begin errors++; $display("[TB] FAIL midword_frame_cnt_after: got %0d, expected 1", frameCnt[0]); end
  endtask

  task automatic test_single_byte_frames();
    int sent = 0;
    int pops = 0;
    int budget;
    logic acc, pop;
    expWord_t obs, exp;
    for (int i = 0; i < 5; i++) expQ.push_back('{{24'h0, 8'(8'hE0 + i)}, 4'h1, 1'b1});
    for (budget = 0; budget < 40 && (sent < 5 || expQ.size() != 0); budget++) begin
      stepCycle(3, sent < 5, 8'(8'hE0 + sent), 1'b1, acc, pop, obs);
      checks++;
      if (frameCnt[3] !== 16'(pops)) begin errors++; $display("[TB] FAIL single_frame_cnt: got %0d, expected %0d", frameCnt[3], pops); end
      if (pop) begin
        pops++;
        checks++;
        if (expQ.size() == 0) begin
          errors++; $display("[TB] FAIL single_extra: got %h, expected no word", obs.data);
        end else begin
          exp = expQ.pop_front();
          if (obs !== exp) begin errors++; $display("[TB] FAIL single_word: got %h/%h/%b, expected %h/%h/%b", obs.data, obs.keep, obs.last, exp.data, exp.keep, exp.last); end
        end
      end
      if (acc) sent++;
    end
    checks++;
    if (sent != 5 || expQ.size() != 0) begin errors++; $display("[TB] FAIL single_timeout: sent %0d, pending %0d, expected 5 and 0", sent, expQ.size()); end
    stepCycle(3, 1'b0, 8'h0, 1'b1, acc, pop, obs);
    checks++;
    if (frameCnt[3] !== 16'd5) begin errors++; $display("[TB] FAIL single_frame_cnt_end: got %0d, expected 5", frameCnt[3]); end

    force gDut[3].dut.frameCntQ = 16'hFFFF;
    #1;
    release gDut[3].dut.frameCntQ;
    #1;
    checks++;
    if (frameCnt[3] !== 16'hFFFF) begin errors++; $display("[TB] FAIL wrap_preset: got %h, expected ffff", frameCnt[3]); end
    sent = 0;
    pops = 0;
    expQ.push_back('{32'h000000F0, 4'h1, 1'b1});
    for (budget = 0; budget < 20 && (sent < 1 || expQ.size() != 0); budget++) begin
      stepCycle(3, sent < 1, 8'hF0, 1'b1, acc, pop, obs);
      if (pop) begin
        pops++;
        checks++;
        exp = expQ.pop_front();
        if (obs !== exp) begin errors++; $display("[TB] FAIL wrap_word: got %h/%h/%b, expected %h/%h/%b", obs.data, obs.keep, obs.last, exp.data, exp.keep, exp.last); end
      end
      if (acc) sent++;
    end
    stepCycle(3, 1'b0, 8'h0, 1'b1, acc, pop, obs);
    checks++;
    if (pops != 1 || frameCnt[3] !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_frame_cnt: got %h after %0d pops, expected 0000 after 1", frameCnt[3], pops); end
  endtask

  // Scenario sequence.
  initial begin
    for (int k = 0; k < NDUT; k++) begin
      inData[k]   = 8'h0;
      inValid[k]  = 1'b0;
      outReady[k] = 1'b1;
    end
    modelReset();
    $display("[TB] layer4_out_packer bench start");
    test_reset();
    test_full_frame();
    test_partial_tail();
    test_backpressure();
    test_random();
    test_reset_mid_word();
    test_single_byte_frames();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/layer4_out_packer.md
# layer4_out_packer

Downstream stage of the Layer 4 pointwise engine: consumes its 8-bit post-ReLU activation stream (`reluRes_V_V_*`) and packs it little-endian into 32-bit AXI-Stream words for the output DMA. It marks each feature-map frame with TLAST and flags a short final word with TKEEP. A 2-entry output FIFO lets the ReLU stream run at one byte per cycle while the DMA side stalls.

## Interface
Parameters:
- `FRAME_BYTES`, default 3136: bytes per output frame (56×56 map). Legal range is 1..65535; it need not be a multiple of 4.
- `FIFO_DEPTH`, fixed at 2: output word buffer depth. Not user-overridable.

Ports:
- `ap_clk`  in  1  the single clock; all logic is rising-edge.
- `ap_rst_n`  in  1  synchronous, active-low reset.
- `reluRes_V_V_TDATA`  in  8  activation byte from Layer 4.
- `reluRes_V_V_TVALID`  in  1  byte valid.
- `reluRes_V_V_TREADY`  out  1  byte accepted when high together with TVALID.
- `OutDMA_V_TDATA`  out  32  packed word; byte k sits at [8k+7:8k].
- `OutDMA_V_TKEEP`  out  4  byte enables.
- `OutDMA_V_TLAST`  out  1  last word of the frame.
- `OutDMA_V_TVALID`  out  1  word valid.
- `OutDMA_V_TREADY`  in  1  DMA accepts the word.
- `frame_cnt`  out  16  count of frames fully emitted; wraps modulo 2^16.

## Operation
- **Byte accept:** a byte is accepted when `in_TVALID && in_TREADY`.
  - `in_TREADY = ap_rst_n && (fifo_count < 2)`. This is combinational and does not depend on `in_TVALID`.
  - The accepted byte is written into lane `lane_idx` of the pack register. `lane_idx` then advances 0→1→2→3→0.
- **Frame counter:** `byte_cnt` (16 bits) counts accepted bytes in the current frame.
- **Word completion:** a word completes when the accepted byte hits lane 3, or when `byte_cnt == FRAME_BYTES-1` (last byte of the frame).
  - On completion the word is pushed into the FIFO with TKEEP = lanes written so far, contiguous from bit 0.
  - TLAST is set on the push caused by the last byte of the frame.
  - Unwritten lanes are zero.
  - The pack register, `lane_idx` and (on frame end) `byte_cnt` clear in the same edge.
- **Frame boundary:** the next frame always starts in lane 0. Bytes are never merged across frames.
- **Output:** the FIFO head drives the `OutDMA_V_*` outputs. A pop happens when `out_TVALID && out_TREADY`.
- **`frame_cnt`:** increments on each pop with TLAST=1.
- **Simultaneous push and pop:** both are allowed in the same cycle; `fifo_count` is unchanged. A push when `fifo_count==2` cannot occur because TREADY is low.
- **Data integrity:** a byte or word is never dropped or duplicated under any TVALID/TREADY pattern.
- **Reset mid-operation** (ap_rst_n low at an edge):
  - The partial word and FIFO contents are discarded.
  - `lane_idx`, `byte_cnt`, `fifo_count` and `frame_cnt` go to 0.
  - The next accepted byte starts a fresh frame.

## Timing
- **Reset values** (while ap_rst_n is low and after the first edge):
  - `reluRes_V_V_TREADY`=0, `OutDMA_V_TVALID`=0, `OutDMA_V_TDATA`=0, `OutDMA_V_TKEEP`=0, `OutDMA_V_TLAST`=0, `frame_cnt`=0.
  - `in_TREADY` rises combinationally in the first cycle with ap_rst_n high.
- **Latency:** a word completed at edge N is valid on `OutDMA_*` after edge N, i.e. 1 cycle from the completing byte handshake to TVALID.
- **AXI-Stream rules:** while TVALID is high and TREADY is low, TDATA/TKEEP/TLAST are held stable.
- **Throughput:**
  - Sustained 1 byte/cycle in, 1 word per 4 cycles out, with `out_TREADY` continuously high.
  - TREADY drops only when 2 words are buffered.
- **Registered outputs:** all outputs except `reluRes_V_V_TREADY` are registered.

## Structure
- **Shared package `layer4_pkg`:** BYTE_W=8, WORD_W=32, LANES=4, KEEP_W=4, and the FRAME_BYTES default for layer 4. Downstream DMA glue reuses these.
- **Sub-module `stream_fifo2`:** 2-entry register FIFO with push/pop/count, parameterised on payload width. Payload is 37 bits: data + keep + last.
- **Top-level logic:** the packing datapath and counters stay in the top module.

## Test plan
1. **Full frame, no stall:** reset, FRAME_BYTES=8, bytes 0x01..0x08 back-to-back, out_TREADY=1.
   - Expect words 0x04030201 (KEEP=F, LAST=0) and 0x08070605 (KEEP=F, LAST=1).
   - frame_cnt=1. Each word appears 1 cycle after its 4th byte.
2. **Partial tail:** FRAME_BYTES=6, bytes 0xA0..0xA5.
   - Expect 0xA3A2A1A0 (KEEP=F), then 0x0000A5A4 (KEEP=3, LAST=1).
   - A following frame starts in lane 0.
3. **Backpressure:** out_TREADY=0 for 20 cycles with input streaming.
   - After 8 bytes are accepted, in_TREADY goes low.
   - Head word is held stable.
   - On release, all words drain in order with none lost.
4. **Randomised TVALID/TREADY:** 10 frames of FRAME_BYTES=3136 with an incrementing byte pattern.
   - Reconstructed byte stream matches exactly.
   - 784 words per frame, TLAST on every 784th word, frame_cnt=10.
5. **Reset mid-word:** ap_rst_n low for 1 cycle after 3 bytes of a frame.
   - No word is emitted for those bytes. Outputs take reset values.
   - The next 4 bytes form one full word with LAST set correctly relative to the new frame.
6. **FRAME_BYTES=1:** each byte yields one word, KEEP=1, LAST=1.
   - frame_cnt increments per pop.
   - frame_cnt wraps from 0xFFFF to 0 (checked with a forced preset).
